// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundles the MEM-stage request side and the 16-bit SRAM pin side of mem_stage_sram_ctrl.
// The master is the pipeline plus the SRAM device. The slave is the controller.
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        address;
    logic [31:0]        writeData;
    logic [31:0]        readData;
    logic               ready;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic               SRAM_WE_N;
    logic [15:0]        SRAM_DQ_OUT;
    logic               SRAM_DQ_OE;
    logic [15:0]        SRAM_DQ_IN;

    modport master (
        output MEM_R_EN, MEM_W_EN, address, writeData, SRAM_DQ_IN,
        input  readData, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, writeData, SRAM_DQ_IN,
        output readData, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM. Each 32-bit access runs as two half-word phases.
// The optional macro SRAM_WRITE_BUFFER_EN enables a one-entry posted-write buffer.
module mem_stage_sram_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stage_sram_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        data_q, data_d;
    logic               wr_q, wr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               we_n_q, we_n_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
`ifdef SRAM_WRITE_BUFFER_EN
    logic               posted_q, posted_d;
`endif

    logic               req_s;
    logic               last_s;
    logic               ready_s;
    logic [31:0]        off_s;

    assign req_s  = bus.MEM_R_EN | bus.MEM_W_EN;
    assign off_s  = bus.address - BASE_W;
    assign last_s = (cnt_q == 4'd0);

    // Next-state, latched operands and SRAM pin values; pins are registered so they hold across a phase
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        data_d      = data_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        we_n_d      = we_n_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        ready_s     = 1'b0;
`ifdef SRAM_WRITE_BUFFER_EN
        posted_d    = posted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_s = ~req_s;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                if (req_s) begin
                    word_d      = off_s[SRAM_AW:2];
                    data_d      = bus.writeData;
                    wr_d        = bus.MEM_W_EN;
                    cnt_d       = WAIT_LD;
                    sram_addr_d = {off_s[SRAM_AW:2], 1'b0};
                    we_n_d      = ~bus.MEM_W_EN;
                    dq_oe_d     = bus.MEM_W_EN;
                    dq_out_d    = bus.writeData[15:0];
                    state_d     = ST_LOW;
`ifdef SRAM_WRITE_BUFFER_EN
                    // A store is posted, so the pipeline advances while it drains.
                    posted_d    = bus.MEM_W_EN;
                    ready_s     = bus.MEM_W_EN;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    if (!wr_q) begin
                        rdata_d[15:0] = bus.SRAM_DQ_IN;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    cnt_d       = WAIT_LD;
                    sram_addr_d = {word_q, 1'b1};
                    dq_out_d    = data_q[31:16];
                    state_d     = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HIGH: begin
                if (last_s) begin
                    if (!wr_q) begin
                        rdata_d[31:16] = bus.SRAM_DQ_IN;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    we_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
`ifdef SRAM_WRITE_BUFFER_EN
                    posted_d = 1'b0;
                    state_d  = posted_q ? ST_IDLE : ST_DONE;
`else
                    state_d  = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                ready_s = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access with the write strobe released at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            data_q      <= 32'd0;
            wr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
`ifdef SRAM_WRITE_BUFFER_EN
            posted_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
`ifdef SRAM_WRITE_BUFFER_EN
            posted_q    <= posted_d;
`endif
        end
    end

    assign bus.readData    = rdata_q;
    assign bus.ready       = ready_s;
    assign bus.SRAM_ADDR   = sram_addr_q;
    assign bus.SRAM_WE_N   = we_n_q;
    assign bus.SRAM_DQ_OUT = dq_out_q;
    assign bus.SRAM_DQ_OE  = dq_oe_q;
endmodule
